// File: rtl/tone_sequencer.sv
// tone_sequencer: steps through a small (pitch, duration) pattern, drives the
// triangle generator's frequency select and gates its PCM stream towards the
// PDM modulator (midscale while muted).
//
// Ports:
//   clk, rst_n     system clock, synchronous active-low reset
//   ena            tick prescaler enable; low freezes prescaler, counter, state
//   load_en        pattern write strobe (honoured only while idle)
//   load_addr      pattern entry to write
//   load_data      [7:4] pitch code, [3:0] duration in ticks (0 = end marker)
//   start          begin playback from entry 0 (level-sampled)
//   stop           abort playback (wins over everything else)
//   loop           restart at entry 0 after the last entry
//   pcm_in         PCM sample from the triangle generator
//   pitch_out      frequency select to the triangle generator
//   pcm_out        gated PCM to the PDM modulator (1-cycle latency)
//   busy           high while playing a note or its trailing gap
//   step_idx       index of the current entry
//   step_strobe    one-cycle pulse on every note start
module tone_sequencer #(
  parameter int unsigned STEPS      = 8,
  parameter int unsigned TICK_DIV   = 12000,
  parameter logic [15:0] MUTE_LEVEL = 16'h8000,
  localparam int unsigned IW = (STEPS > 1) ? $clog2(STEPS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          load_en,
  input  logic [IW-1:0] load_addr,
  input  logic [7:0]    load_data,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  input  logic [15:0]   pcm_in,
  output logic [3:0]    pitch_out,
  output logic [15:0]   pcm_out,
  output logic          busy,
  output logic [IW-1:0] step_idx,
  output logic          step_strobe
);

  localparam int unsigned PW = $clog2(TICK_DIV);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]    state_q,  state_d;
  logic [PW-1:0] presc_q,  presc_d;
  logic [3:0]    rem_q,    rem_d;
  logic [IW-1:0] idx_q,    idx_d;
  logic [3:0]    pitch_q,  pitch_d;
  logic [15:0]   pcm_q,    pcm_d;
  logic          busy_q,   busy_d;
  logic          strobe_q, strobe_d;
  logic [7:0]    mem_q [STEPS];
  logic [7:0]    mem_d [STEPS];

  logic          tick_c;
  logic          entry0_ok_c;
  logic          last_step_c;
  logic [IW-1:0] next_idx_c;
  logic          go_c;
  logic [IW-1:0] go_idx_c;

  assign tick_c      = ena && (presc_q == PW'(TICK_DIV - 1));
  assign entry0_ok_c = (mem_q[0][3:0] != 4'd0);
  assign last_step_c = (idx_q == IW'(STEPS - 1));
  assign next_idx_c  = idx_q + IW'(1);

  // Next-state, pattern write and output computation
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    rem_d    = rem_q;
    idx_d    = idx_q;
    pitch_d  = pitch_q;
    strobe_d = 1'b0;
    mem_d    = mem_q;
    go_c     = 1'b0;
    go_idx_c = '0;

    if (load_en && (state_q == ST_IDLE)) begin
      mem_d[load_addr] = load_data;
    end

    case (state_q)
      ST_PLAY: begin
        if (tick_c) begin
          presc_d = '0;
          if (rem_q == 4'd1) begin
            state_d = ST_GAP;
            rem_d   = 4'd0;
          end else begin
            rem_d = rem_q - 4'd1;
          end
        end else if (ena) begin
          presc_d = presc_q + PW'(1);
        end
      end
      ST_GAP: begin
        if (tick_c) begin
          presc_d = '0;
          // The last entry never reads past the end; only loop can wrap.
          if (!last_step_c && (mem_q[next_idx_c][3:0] != 4'd0)) begin
            go_c     = 1'b1;
            go_idx_c = next_idx_c;
          end else if (loop && entry0_ok_c) begin
            go_c     = 1'b1;
            go_idx_c = '0;
          end else begin
            state_d = ST_IDLE;
            pitch_d = 4'd0;
            idx_d   = '0;
          end
        end else if (ena) begin
          presc_d = presc_q + PW'(1);
        end
      end
      default: begin
        presc_d = '0;
        if (ena && start && entry0_ok_c) begin
          go_c     = 1'b1;
          go_idx_c = '0;
        end
      end
    endcase

    // Note start: load the entry and restart the prescaler.
    if (go_c) begin
      state_d  = ST_PLAY;
      idx_d    = go_idx_c;
      pitch_d  = mem_q[go_idx_c][7:4];
      rem_d    = mem_q[go_idx_c][3:0];
      presc_d  = '0;
      strobe_d = 1'b1;
    end

    // Abort overrides any tick or start in the same cycle.
    if (stop) begin
      state_d  = ST_IDLE;
      pitch_d  = 4'd0;
      idx_d    = '0;
      presc_d  = '0;
      rem_d    = 4'd0;
      strobe_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
    pcm_d  = (state_q == ST_PLAY) ? pcm_in : MUTE_LEVEL;
  end

  // State and pattern registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      rem_q    <= 4'd0;
      idx_q    <= '0;
      pitch_q  <= 4'd0;
      pcm_q    <= MUTE_LEVEL;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
      for (int i = 0; i < int'(STEPS); i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      rem_q    <= rem_d;
      idx_q    <= idx_d;
      pitch_q  <= pitch_d;
      pcm_q    <= pcm_d;
      busy_q   <= busy_d;
      strobe_q <= strobe_d;
      mem_q    <= mem_d;
    end
  end

  assign pitch_out   = pitch_q;
  assign pcm_out     = pcm_q;
  assign busy        = busy_q;
  assign step_idx    = idx_q;
  assign step_strobe = strobe_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with TICK_DIV=4, STEPS=8.
module tb_tone_sequencer;

  localparam int unsigned IW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          load_en;
  logic [IW-1:0] load_addr;
  logic [7:0]    load_data;
  logic          start;
  logic          stop;
  logic          loop;
  logic [15:0]   pcm_in;
  logic [3:0]    pitch_out;
  logic [15:0]   pcm_out;
  logic          busy;
  logic [IW-1:0] step_idx;
  logic          step_strobe;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected per-cycle schedule, cycle 0 = first cycle after the start edge
  logic [3:0]    e_pitch  [$];
  logic [IW-1:0] e_idx    [$];
  bit            e_play   [$];
  bit            e_strobe [$];

  tone_sequencer #(.STEPS(8), .TICK_DIV(4), .MUTE_LEVEL(16'h8000)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .start(start),
    .stop(stop), .loop(loop), .pcm_in(pcm_in), .pitch_out(pitch_out),
    .pcm_out(pcm_out), .busy(busy), .step_idx(step_idx),
    .step_strobe(step_strobe)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_entry(input logic [IW-1:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  // A note of d ticks plays 4*d cycles then holds its pitch through a 4-cycle gap
  task automatic add_note(input logic [3:0] p, input int d, input logic [IW-1:0] k);
    for (int i = 0; i < 4 * d + 4; i++) begin
      e_pitch.push_back(p);
      e_idx.push_back(k);
      e_play.push_back(i < 4 * d);
      e_strobe.push_back(i == 0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; start = 1'b1; stop = 1'b0; loop = 1'b0;
    load_en = 1'b1; load_addr = '0; load_data = 8'h52; pcm_in = 16'h1234;
    step(); step();
    n_checks++; if (pitch_out !== 4'd0) $display("FAIL rst_pitch got %h exp 0", pitch_out); else n_pass++;
    n_checks++; if (pcm_out !== 16'h8000) $display("FAIL rst_pcm got %h exp 8000", pcm_out); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (step_idx !== 3'd0) $display("FAIL rst_idx got %0d exp 0", step_idx); else n_pass++;
    n_checks++; if (step_strobe !== 1'b0) $display("FAIL rst_strobe got %b exp 0", step_strobe); else n_pass++;
    rst_n = 1'b1; load_en = 1'b0;
    // mem[0] is still empty, so a held start must not begin playback
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++; if (busy !== 1'b0) $display("FAIL rst_start_busy c=%0d got %b exp 0", c, busy); else n_pass++;
      n_checks++; if (step_strobe !== 1'b0) $display("FAIL rst_start_strobe c=%0d got %b exp 0", c, step_strobe); else n_pass++;
      n_checks++; if (pcm_out !== 16'h8000) $display("FAIL rst_start_pcm c=%0d got %h exp 8000", c, pcm_out); else n_pass++;
    end
    start = 1'b0;
  endtask

  task automatic test_play();
    logic [15:0] drv_prev;
    logic [15:0] exp_pcm;
    int n_strobe = 0;
    int n_busy = 0;
    e_pitch.delete(); e_idx.delete(); e_play.delete(); e_strobe.delete();
    add_note(4'd5, 2, 3'd0); add_note(4'd9, 3, 3'd1); add_note(4'd1, 1, 3'd2);
    load_entry(3'd0, 8'h52); load_entry(3'd1, 8'h93);
    load_entry(3'd2, 8'h11); load_entry(3'd3, 8'h00);
    loop = 1'b0; start = 1'b1; pcm_in = 16'h0F0F; drv_prev = pcm_in;
    step(); start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c < e_play.size()) begin
        n_checks++; if (busy !== 1'b1) $display("FAIL play_busy c=%0d got %b exp 1", c, busy); else n_pass++;
        n_checks++; if (pitch_out !== e_pitch[c]) $display("FAIL play_pitch c=%0d got %h exp %h", c, pitch_out, e_pitch[c]); else n_pass++;
        n_checks++; if (step_idx !== e_idx[c]) $display("FAIL play_idx c=%0d got %0d exp %0d", c, step_idx, e_idx[c]); else n_pass++;
        n_checks++; if (step_strobe !== e_strobe[c]) $display("FAIL play_strobe c=%0d got %b exp %b", c, step_strobe, e_strobe[c]); else n_pass++;
      end else begin
        n_checks++; if (busy !== 1'b0) $display("FAIL play_idle c=%0d got %b exp 0", c, busy); else n_pass++;
        n_checks++; if (step_strobe !== 1'b0) $display("FAIL play_idle_strobe c=%0d got %b exp 0", c, step_strobe); else n_pass++;
      end
      exp_pcm = (c >= 1 && (c - 1) < e_play.size() && e_play[c-1]) ? drv_prev : 16'h8000;
      n_checks++; if (pcm_out !== exp_pcm) $display("FAIL play_pcm c=%0d got %h exp %h", c, pcm_out, exp_pcm); else n_pass++;
      if (step_strobe === 1'b1) n_strobe++;
      if (busy === 1'b1) n_busy++;
      pcm_in = 16'(16'h1000 + 16'(c * 37)); drv_prev = pcm_in;
      step();
    end
    n_checks++; if (n_strobe != 3) $display("FAIL play_strobe_count got %0d exp 3", n_strobe); else n_pass++;
    n_checks++; if (n_busy != 36) $display("FAIL play_busy_cycles got %0d exp 36", n_busy); else n_pass++;
  endtask

  task automatic test_loop();
    loop = 1'b1; start = 1'b1;
    step(); start = 1'b0;
    for (int c = 0; c < 76; c++) begin
      if (c == 12 || c == 48) begin
        n_checks++; if (step_idx !== 3'd1 || step_strobe !== 1'b1) $display("FAIL loop_e1 c=%0d got idx %0d stb %b exp 1 1", c, step_idx, step_strobe); else n_pass++;
      end
      if (c == 28 || c == 64) begin
        n_checks++; if (step_idx !== 3'd2 || pitch_out !== 4'd1) $display("FAIL loop_e2 c=%0d got idx %0d pitch %h exp 2 1", c, step_idx, pitch_out); else n_pass++;
      end
      if (c == 35) begin
        n_checks++; if (busy !== 1'b1 || pitch_out !== 4'd1) $display("FAIL loop_gap c=%0d got busy %b pitch %h exp 1 1", c, busy, pitch_out); else n_pass++;
      end
      if (c == 36) begin
        n_checks++; if (step_idx !== 3'd0) $display("FAIL loop_wrap_idx got %0d exp 0", step_idx); else n_pass++;
        n_checks++; if (pitch_out !== 4'd5) $display("FAIL loop_wrap_pitch got %h exp 5", pitch_out); else n_pass++;
        n_checks++; if (step_strobe !== 1'b1) $display("FAIL loop_wrap_strobe got %b exp 1", step_strobe); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL loop_wrap_busy got %b exp 1", busy); else n_pass++;
      end
      if (c == 40) loop = 1'b0;
      if (c == 71) begin
        n_checks++; if (busy !== 1'b1) $display("FAIL loop_end_busy c=71 got %b exp 1", busy); else n_pass++;
      end
      if (c >= 72) begin
        n_checks++; if (busy !== 1'b0) $display("FAIL loop_end_idle c=%0d got %b exp 0", c, busy); else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_stop();
    logic [15:0] drv17;
    drv17 = 16'h0;
    loop = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    for (int c = 0; c < 22; c++) begin
      if (c == 17) begin
        n_checks++; if (busy !== 1'b1 || pitch_out !== 4'd9) $display("FAIL stop_pre got busy %b pitch %h exp 1 9", busy, pitch_out); else n_pass++;
        stop = 1'b1;
      end
      if (c == 18) begin
        n_checks++; if (busy !== 1'b0) $display("FAIL stop_busy got %b exp 0", busy); else n_pass++;
        n_checks++; if (pitch_out !== 4'd0) $display("FAIL stop_pitch got %h exp 0", pitch_out); else n_pass++;
        n_checks++; if (step_idx !== 3'd0) $display("FAIL stop_idx got %0d exp 0", step_idx); else n_pass++;
        n_checks++; if (pcm_out !== drv17) $display("FAIL stop_pcm_lat got %h exp %h", pcm_out, drv17); else n_pass++;
        stop = 1'b0;
      end
      if (c == 19) begin
        n_checks++; if (pcm_out !== 16'h8000) $display("FAIL stop_pcm_mute got %h exp 8000", pcm_out); else n_pass++;
      end
      pcm_in = 16'(16'h4000 + 16'(c * 11));
      if (c == 17) drv17 = pcm_in;
      step();
    end
    start = 1'b1; stop = 1'b1;
    step();
    n_checks++; if (busy !== 1'b0 || step_strobe !== 1'b0) $display("FAIL stop_vs_start got busy %b stb %b exp 0 0", busy, step_strobe); else n_pass++;
    start = 1'b0; stop = 1'b0;
    step();
    n_checks++; if (busy !== 1'b0) $display("FAIL stop_vs_start_after got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] drv7;
    drv7 = 16'h0;
    // Writes and a repeated start during playback must be ignored
    start = 1'b1;
    step(); start = 1'b0;
    for (int c = 0; c < 38; c++) begin
      if (c == 6) begin
        n_checks++; if (step_strobe !== 1'b0 || step_idx !== 3'd0) $display("FAIL lock_restart got stb %b idx %0d exp 0 0", step_strobe, step_idx); else n_pass++;
      end
      if (c == 12) begin
        n_checks++; if (pitch_out !== 4'd9 || step_strobe !== 1'b1) $display("FAIL lock_e1 got pitch %h stb %b exp 9 1", pitch_out, step_strobe); else n_pass++;
      end
      if (c == 23) begin
        n_checks++; if (pitch_out !== 4'd9 || busy !== 1'b1) $display("FAIL lock_e1_len got pitch %h busy %b exp 9 1", pitch_out, busy); else n_pass++;
      end
      if (c == 28) begin
        n_checks++; if (step_idx !== 3'd2 || step_strobe !== 1'b1) $display("FAIL lock_e2 got idx %0d stb %b exp 2 1", step_idx, step_strobe); else n_pass++;
      end
      if (c == 35 || c == 36) begin
        n_checks++; if (busy !== (c == 35)) $display("FAIL lock_end c=%0d got %b exp %b", c, busy, (c == 35)); else n_pass++;
      end
      load_en = (c == 5); load_addr = 3'd1; load_data = 8'hF1; start = (c == 5);
      step();
    end
    load_en = 1'b0; start = 1'b0;
    // Freeze for 10 edges in the middle of the first note
    start = 1'b1;
    step(); start = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (c == 8) begin
        n_checks++; if (pcm_out !== drv7) $display("FAIL ena_pcm got %h exp %h", pcm_out, drv7); else n_pass++;
        n_checks++; if (pitch_out !== 4'd5 || busy !== 1'b1) $display("FAIL ena_hold got pitch %h busy %b exp 5 1", pitch_out, busy); else n_pass++;
      end
      if (c == 21) begin
        n_checks++; if (step_idx !== 3'd0 || step_strobe !== 1'b0 || busy !== 1'b1) $display("FAIL ena_gap got idx %0d stb %b busy %b exp 0 0 1", step_idx, step_strobe, busy); else n_pass++;
      end
      if (c == 22) begin
        n_checks++; if (step_idx !== 3'd1 || step_strobe !== 1'b1 || pitch_out !== 4'd9) $display("FAIL ena_e1 got idx %0d stb %b pitch %h exp 1 1 9", step_idx, step_strobe, pitch_out); else n_pass++;
      end
      if (c == 3) ena = 1'b0;
      if (c == 13) ena = 1'b1;
      pcm_in = 16'(16'h6000 + 16'(c * 5));
      if (c == 7) drv7 = pcm_in;
      step();
    end
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic test_all_steps();
    int n_strobe = 0;
    for (int i = 0; i < 8; i++) load_entry(3'(i), {4'(15 - i), 4'd1});
    loop = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    for (int c = 0; c < 70; c++) begin
      if (c < 64 && (c % 8) == 0) begin
        n_checks++; if (step_strobe !== 1'b1 || step_idx !== 3'(c / 8) || pitch_out !== 4'(15 - c / 8))
          $display("FAIL all_note c=%0d got stb %b idx %0d pitch %h exp 1 %0d %h", c, step_strobe, step_idx, pitch_out, c / 8, 4'(15 - c / 8));
        else n_pass++;
      end
      n_checks++; if (busy !== (c < 64)) $display("FAIL all_busy c=%0d got %b exp %b", c, busy, (c < 64)); else n_pass++;
      if (step_strobe === 1'b1) n_strobe++;
      step();
    end
    n_checks++; if (n_strobe != 8) $display("FAIL all_strobe_count got %0d exp 8", n_strobe); else n_pass++;
    load_entry(3'd0, 8'h70);
    start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      n_checks++; if (busy !== 1'b0 || step_strobe !== 1'b0) $display("FAIL end_marker c=%0d got busy %b stb %b exp 0 0", c, busy, step_strobe); else n_pass++;
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_play();
    test_loop();
    test_stop();
    test_back_to_back();
    test_all_steps();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
